// File: rtl/dmem_rmw_unit.sv
// dmem_rmw_unit: read-modify-write sequencer between the DRAM controller and
// the synchronous data RAM. Full-word stores go straight through, byte and
// halfword stores become read -> merge -> write while the core is stalled.

package dmem_rmw_pkg;
    typedef enum logic [1:0] {
        sb_conf = 2'd0,
        sh_conf = 2'd1,
        sw_conf = 2'd2
    } store_conf;
endpackage

module dmem_rmw_unit
    import dmem_rmw_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dram_address,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] dram_datain,
    input  store_conf         store_type,
    input  logic              dram_re,
    input  logic              dram_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] dmem_word,
    output logic              stall,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_RD_LAT - 1);

    state_t            state;
    state_t            state_n;
    logic [2:0]        lat_cnt;
    logic              accept;

    // latched sub-word store request
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [15:0]       data_q;
    store_conf         type_q;

    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] merge_q;

    // Byte-lane merge of the latched store data into the word read back from RAM
    always_comb begin
        merged = mem_rdata;
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            if (2'(i) == off_q) begin
                merged[8*i +: 8] = data_q[7:0];
            end else if (type_q == sh_conf && 2'(i) == off_q + 2'd1) begin
                merged[8*i +: 8] = data_q[15:8];
            end
        end
    end

    // Next-state and RAM-side outputs; reset forces every output low
    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        mem_addr     = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        case (state)
            IDLE: begin
                if (dram_we) begin
                    case (store_type)
                        sw_conf: begin
                            mem_we    = 1'b1;
                            mem_addr  = dram_address;
                            mem_wdata = dram_datain;
                        end
                        sb_conf, sh_conf: begin
                            if (store_type == sh_conf && byte_off[0]) begin
                                misalign_err = 1'b1;
                            end else begin
                                accept   = 1'b1;
                                mem_re   = 1'b1;
                                mem_addr = dram_address;
                                stall    = 1'b1;
                                state_n  = RD_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end else if (dram_re) begin
                    mem_re   = 1'b1;
                    mem_addr = dram_address;
                end
            end
            RD_WAIT: begin
                stall    = 1'b1;
                mem_addr = addr_q;
                if (lat_cnt == '0) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            accept       = 1'b0;
            mem_addr     = '0;
            mem_re       = 1'b0;
            mem_we       = 1'b0;
            mem_wdata    = '0;
            stall        = 1'b0;
            misalign_err = 1'b0;
        end
    end

    // State register, latency counter, request latch and merged-word capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            data_q  <= '0;
            type_q  <= sb_conf;
            merge_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= dram_address;
                off_q   <= byte_off;
                data_q  <= dram_datain[15:0];
                type_q  <= store_type;
                lat_cnt <= LAT_INIT;
            end else if (state == RD_WAIT) begin
                if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - 3'd1;
                end else begin
                    merge_q <= merged;
                end
            end
        end
    end

    assign dmem_word = mem_rdata;

endmodule

// File: tb/tb_dmem_rmw_unit.sv
// Testbench for dmem_rmw_unit: two instances (read latency 1 and 3), each with
// its own behavioural RAM, checked against a word-level reference memory.

module tb_dmem_rmw_unit;
    import dmem_rmw_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 9;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    int tests_run = 0;
    int fails     = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] d_addr [2];
    logic [1:0]    d_off  [2];
    logic [DW-1:0] d_data [2];
    store_conf     d_type [2];
    logic          d_re   [2];
    logic          d_we   [2];
    logic [DW-1:0] rdata  [2];
    logic [AW-1:0] o_addr [2];
    logic          o_re   [2];
    logic          o_we   [2];
    logic [DW-1:0] o_wdata[2];
    logic [DW-1:0] o_word [2];
    logic          o_stall[2];
    logic          o_merr [2];

    logic [DW-1:0] ref_mem [2][512];

    dmem_rmw_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_RD_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst), .dram_address(d_addr[0]), .byte_off(d_off[0]),
        .dram_datain(d_data[0]), .store_type(d_type[0]), .dram_re(d_re[0]),
        .dram_we(d_we[0]), .mem_rdata(rdata[0]), .mem_addr(o_addr[0]),
        .mem_re(o_re[0]), .mem_we(o_we[0]), .mem_wdata(o_wdata[0]),
        .dmem_word(o_word[0]), .stall(o_stall[0]), .misalign_err(o_merr[0])
    );

    dmem_rmw_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_RD_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst), .dram_address(d_addr[1]), .byte_off(d_off[1]),
        .dram_datain(d_data[1]), .store_type(d_type[1]), .dram_re(d_re[1]),
        .dram_we(d_we[1]), .mem_rdata(rdata[1]), .mem_addr(o_addr[1]),
        .mem_re(o_re[1]), .mem_we(o_we[1]), .mem_wdata(o_wdata[1]),
        .dmem_word(o_word[1]), .stall(o_stall[1]), .misalign_err(o_merr[1])
    );

    // RAM models: writes visible to later reads, read data after the set latency
    logic [DW-1:0] ram0 [512];
    logic [DW-1:0] ram1 [512];
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1 [3];

    always @(posedge clk) begin
        if (o_we[0]) ram0[o_addr[0]] <= o_wdata[0];
        pipe0 <= o_re[0] ? ram0[o_addr[0]] : $urandom;
    end
    assign rdata[0] = pipe0;

    always @(posedge clk) begin
        if (o_we[1]) ram1[o_addr[1]] <= o_wdata[1];
        pipe1[0] <= o_re[1] ? ram1[o_addr[1]] : $urandom;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rdata[1] = pipe1[2];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // Reference model of one store: updates ref_mem, returns expected behaviour
    task automatic ref_store(input int k, input logic [AW-1:0] a, input logic [1:0] off,
                             input logic [DW-1:0] data, input store_conf st,
                             output int e_we, output logic [DW-1:0] e_wd,
                             output int e_stall, output logic e_merr);
        logic [DW-1:0] mask;
        logic [DW-1:0] ins;
        int            sh;
        sh      = 8 * int'(off);
        e_we    = 1;
        e_stall = 1 + lat_of(k);
        e_merr  = 1'b0;
        if (st == sw_conf) begin
            e_stall = 0;
            e_wd    = data;
        end else if (st == sh_conf && off[0]) begin
            e_we    = 0;
            e_stall = 0;
            e_merr  = 1'b1;
            e_wd    = ref_mem[k][a];
        end else begin
            if (st == sb_conf) begin
                mask = 32'h0000_00FF << sh;
                ins  = (data & 32'h0000_00FF) << sh;
            end else begin
                mask = 32'h0000_FFFF << sh;
                ins  = (data & 32'h0000_FFFF) << sh;
            end
            e_wd = (ref_mem[k][a] & ~mask) | ins;
        end
        ref_mem[k][a] = e_wd;
    endtask

    // Present a store and hold it while stalled; called #1 after a rising edge
    task automatic do_store(input int k, input logic [AW-1:0] a, input logic [1:0] off,
                            input logic [DW-1:0] data, input store_conf st, input logic also_re,
                            output int stall_n, output int we_n, output logic [AW-1:0] wa,
                            output logic [DW-1:0] wd, output logic merr, output logic re_first,
                            output logic done);
        stall_n = 0; we_n = 0; wa = '0; wd = '0; merr = 1'b0; re_first = 1'b0; done = 1'b0;
        d_addr[k] = a; d_off[k] = off; d_data[k] = data; d_type[k] = st;
        d_we[k] = 1'b1; d_re[k] = also_re;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (c == 0) re_first = o_re[k];
            if (o_stall[k]) stall_n++;
            if (o_merr[k]) merr = 1'b1;
            if (o_we[k]) begin
                we_n++;
                wa = o_addr[k];
                wd = o_wdata[k];
            end
            if (!o_stall[k]) done = 1'b1;
        end
        @(posedge clk); #1;
        d_we[k] = 1'b0;
        d_re[k] = 1'b0;
    endtask

    task automatic do_load(input int k, input logic [AW-1:0] a,
                           output logic re0, output logic st0, output logic [DW-1:0] word);
        d_addr[k] = a; d_re[k] = 1'b1; d_we[k] = 1'b0;
        @(negedge clk);
        re0 = o_re[k];
        st0 = o_stall[k];
        @(posedge clk); #1;
        d_re[k] = 1'b0;
        repeat (lat_of(k) - 1) @(posedge clk);
        @(negedge clk);
        word = o_word[k];
        @(posedge clk); #1;
    endtask

    // Unchecked full-word preset through the DUT, mirrored in the model
    task automatic preset(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v);
        int st_n, we_n, e_we, e_st;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, e_wd;
        logic mr, rf, dn, e_mr;
        ref_store(k, a, 2'd0, v, sw_conf, e_we, e_wd, e_st, e_mr);
        do_store(k, a, 2'd0, v, sw_conf, 1'b0, st_n, we_n, wa, wd, mr, rf, dn);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d_addr[k] = 9'h155; d_off[k] = 2'd1; d_data[k] = 32'hCAFE_F00D;
            d_type[k] = sw_conf; d_we[k] = 1'b1; d_re[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if ({o_we[k], o_re[k], o_stall[k], o_merr[k]} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_ctrl[%0d]: got we/re/stall/merr=%b expected 0000", k,
                         {o_we[k], o_re[k], o_stall[k], o_merr[k]});
            end
            tests_run++;
            if (o_addr[k] !== '0 || o_wdata[k] !== '0) begin
                fails++;
                $display("FAIL reset_bus[%0d]: got addr=%h wdata=%h expected 0/0", k, o_addr[k], o_wdata[k]);
            end
            tests_run++;
            if (o_word[k] !== rdata[k]) begin
                fails++;
                $display("FAIL reset_dmem_word[%0d]: got %h expected %h", k, o_word[k], rdata[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            d_we[k] = 1'b0; d_re[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (o_stall[k] !== 1'b0 || o_we[k] !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle[%0d]: got stall=%b we=%b expected 0/0", k, o_stall[k], o_we[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sb();
        int st_n, we_n, e_we, e_st;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, e_wd, word;
        logic mr, rf, dn, e_mr, re0, st0;
        preset(0, 9'h012, 32'hAABB_CCDD);
        ref_store(0, 9'h012, 2'd2, 32'h0000_00EE, sb_conf, e_we, e_wd, e_st, e_mr);
        do_store(0, 9'h012, 2'd2, 32'h0000_00EE, sb_conf, 1'b0, st_n, we_n, wa, wd, mr, rf, dn);
        tests_run++;
        if (!dn || st_n != e_st || rf !== 1'b1) begin
            fails++;
            $display("FAIL sb_stall: got done=%b stall_cycles=%0d re_first=%b expected 1/%0d/1", dn, st_n, rf, e_st);
        end
        tests_run++;
        if (we_n != e_we || wa !== 9'h012 || wd !== e_wd) begin
            fails++;
            $display("FAIL sb_write: got we_n=%0d addr=%h wdata=%h expected %0d/012/%h", we_n, wa, wd, e_we, e_wd);
        end
        do_load(0, 9'h012, re0, st0, word);
        tests_run++;
        if (word !== ref_mem[0][9'h012]) begin
            fails++;
            $display("FAIL sb_readback: got %h expected %h", word, ref_mem[0][9'h012]);
        end
    endtask

    task automatic test_sh();
        int st_n, we_n, e_we, e_st;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, e_wd;
        logic mr, rf, dn, e_mr;
        preset(0, 9'h020, 32'hAABB_CCDD);
        ref_store(0, 9'h020, 2'd2, 32'h0000_1234, sh_conf, e_we, e_wd, e_st, e_mr);
        do_store(0, 9'h020, 2'd2, 32'h0000_1234, sh_conf, 1'b0, st_n, we_n, wa, wd, mr, rf, dn);
        tests_run++;
        if (!dn || st_n != e_st || we_n != e_we || wa !== 9'h020 || wd !== e_wd) begin
            fails++;
            $display("FAIL sh_aligned: got stall=%0d we_n=%0d addr=%h wdata=%h expected %0d/%0d/020/%h",
                     st_n, we_n, wa, wd, e_st, e_we, e_wd);
        end
        for (int o = 1; o < 4; o += 2) begin
            ref_store(0, 9'h020, 2'(o), 32'h0000_5678, sh_conf, e_we, e_wd, e_st, e_mr);
            do_store(0, 9'h020, 2'(o), 32'h0000_5678, sh_conf, 1'b0, st_n, we_n, wa, wd, mr, rf, dn);
            tests_run++;
            if (!dn || mr !== 1'b1 || we_n != 0 || st_n != 0 || rf !== 1'b0) begin
                fails++;
                $display("FAIL sh_misalign_off%0d: got merr=%b we_n=%0d stall=%0d re=%b expected 1/0/0/0",
                         o, mr, we_n, st_n, rf);
            end
        end
        @(negedge clk);
        tests_run++;
        if (o_merr[0] !== 1'b0) begin
            fails++;
            $display("FAIL misalign_pulse_width: got merr=%b expected 0", o_merr[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_load();
        int st_n, we_n, e_we, e_st;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, e_wd, word;
        logic mr, rf, dn, e_mr, re0, st0;
        for (int k = 0; k < 2; k++) begin
            ref_store(k, 9'h1FF, 2'd0, 32'hDEAD_BEEF, sw_conf, e_we, e_wd, e_st, e_mr);
            do_store(k, 9'h1FF, 2'd0, 32'hDEAD_BEEF, sw_conf, 1'b1, st_n, we_n, wa, wd, mr, rf, dn);
            tests_run++;
            if (!dn || st_n != 0 || rf !== 1'b0 || we_n != 1 || wa !== 9'h1FF || wd !== e_wd) begin
                fails++;
                $display("FAIL sw_with_re[%0d]: got stall=%0d re=%b we_n=%0d addr=%h wdata=%h expected 0/0/1/1ff/%h",
                         k, st_n, rf, we_n, wa, wd, e_wd);
            end
            do_load(k, 9'h1FF, re0, st0, word);
            tests_run++;
            if (re0 !== 1'b1 || st0 !== 1'b0 || word !== ref_mem[k][9'h1FF]) begin
                fails++;
                $display("FAIL sw_load[%0d]: got re=%b stall=%b word=%h expected 1/0/%h",
                         k, re0, st0, word, ref_mem[k][9'h1FF]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int we_seen;
        int stall_seen;
        logic [DW-1:0] word;
        logic re0, st0;
        preset(0, 9'h040, 32'h0102_0304);
        d_addr[0] = 9'h040; d_off[0] = 2'd1; d_data[0] = 32'h0000_0055;
        d_type[0] = sb_conf; d_we[0] = 1'b1; d_re[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (o_stall[0] !== 1'b1 || o_re[0] !== 1'b1) begin
            fails++;
            $display("FAIL rmw_accept: got stall=%b re=%b expected 1/1", o_stall[0], o_re[0]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        d_we[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({o_we[0], o_re[0], o_stall[0], o_merr[0]} !== 4'b0000 || o_addr[0] !== '0) begin
            fails++;
            $display("FAIL rst_in_rd_wait: got we/re/stall/merr=%b addr=%h expected 0000/000",
                     {o_we[0], o_re[0], o_stall[0], o_merr[0]}, o_addr[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        we_seen = 0;
        stall_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_we[0]) we_seen++;
            if (o_stall[0]) stall_seen++;
        end
        tests_run++;
        if (we_seen != 0 || stall_seen != 0) begin
            fails++;
            $display("FAIL rst_abandon: got we_pulses=%0d stall_cycles=%0d expected 0/0", we_seen, stall_seen);
        end
        @(posedge clk); #1;
        do_load(0, 9'h040, re0, st0, word);
        tests_run++;
        if (word !== ref_mem[0][9'h040]) begin
            fails++;
            $display("FAIL rst_word_kept: got %h expected %h", word, ref_mem[0][9'h040]);
        end
    endtask

    task automatic test_back_to_back();
        int st_n, we_n, e_we, e_st;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, e_wd, word;
        logic mr, rf, dn, e_mr, re0, st0;
        logic [1:0] offs [2];
        logic [DW-1:0] vals [2];
        offs[0] = 2'd0; offs[1] = 2'd3;
        vals[0] = 32'h0000_0011; vals[1] = 32'h0000_0044;
        for (int k = 0; k < 2; k++) begin
            preset(k, 9'h033, 32'h0000_0000);
            for (int j = 0; j < 2; j++) begin
                ref_store(k, 9'h033, offs[j], vals[j], sb_conf, e_we, e_wd, e_st, e_mr);
                do_store(k, 9'h033, offs[j], vals[j], sb_conf, 1'b0, st_n, we_n, wa, wd, mr, rf, dn);
                tests_run++;
                if (!dn || st_n != e_st || we_n != 1 || wa !== 9'h033 || wd !== e_wd) begin
                    fails++;
                    $display("FAIL b2b[%0d.%0d]: got stall=%0d we_n=%0d addr=%h wdata=%h expected %0d/1/033/%h",
                             k, j, st_n, we_n, wa, wd, e_st, e_wd);
                end
            end
            do_load(k, 9'h033, re0, st0, word);
            tests_run++;
            if (word !== ref_mem[k][9'h033]) begin
                fails++;
                $display("FAIL b2b_final[%0d]: got %h expected %h", k, word, ref_mem[k][9'h033]);
            end
        end
    endtask

    task automatic test_random();
        int st_n, we_n, e_we, e_st;
        logic [AW-1:0] wa, a;
        logic [DW-1:0] wd, e_wd, word, data;
        logic [1:0] off;
        logic mr, rf, dn, e_mr, re0, st0, also_re;
        store_conf st;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) preset(k, 9'(i), $urandom);
            for (int n = 0; n < 50; n++) begin
                a = 9'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) begin
                    do_load(k, a, re0, st0, word);
                    tests_run++;
                    if (re0 !== 1'b1 || st0 !== 1'b0 || word !== ref_mem[k][a]) begin
                        fails++;
                        $display("FAIL rand_load[%0d.%0d]: got re=%b stall=%b word=%h expected 1/0/%h",
                                 k, n, re0, st0, word, ref_mem[k][a]);
                    end
                end else begin
                    off     = 2'($urandom_range(0, 3));
                    data    = $urandom;
                    st      = store_conf'($urandom_range(0, 2));
                    also_re = 1'($urandom_range(0, 1));
                    ref_store(k, a, off, data, st, e_we, e_wd, e_st, e_mr);
                    do_store(k, a, off, data, st, also_re, st_n, we_n, wa, wd, mr, rf, dn);
                    tests_run++;
                    if (!dn || st_n != e_st || we_n != e_we || mr !== e_mr ||
                        (e_we == 1 && (wa !== a || wd !== e_wd))) begin
                        fails++;
                        $display("FAIL rand_store[%0d.%0d]: got stall=%0d we_n=%0d merr=%b addr=%h wdata=%h expected %0d/%0d/%b/%h/%h",
                                 k, n, st_n, we_n, mr, wa, wd, e_st, e_we, e_mr, a, e_wd);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            d_addr[k] = '0; d_off[k] = '0; d_data[k] = '0;
            d_type[k] = sb_conf; d_re[k] = 1'b0; d_we[k] = 1'b0;
        end
        rst = 1'b1;
        test_reset();
        test_sb();
        test_sh();
        test_sw_load();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
